lfsr_rr_sched: RTL and testbench
================================

Name: lfsr_rr_sched

Overview:
Round-robin scheduler that shares one Fibonacci LFSR between NREQ requesters. Each granted request receives the current LFSR word, and the LFSR advances exactly once per grant. The block also handles seeding from a side port and recovery from the all-zero lock-up state. It sits between the pseudo-random consumers and the LFSR core, and is the only block that steps or loads the LFSR.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 4, LFSR width in bits
TAPS, 4'b1100, feedback mask; fb = XOR-reduce(state & TAPS); default polynomial x^4+x^3+1
SEED, 4'b0001, reset/fallback LFSR value; must be nonzero

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 clears the block immediately)
req  in  NREQ  per-requester request level; held until the matching gnt is seen
gnt  out  NREQ  one-hot, single-cycle grant pulse, registered
rnd  out  WIDTH  random word for the granted requester, registered; holds last value between grants
rnd_valid  out  1  high in the same cycle as any gnt bit
seed_valid  in  1  request to load the seed input into the LFSR
seed  in  WIDTH  seed value
seed_ready  out  1  single-cycle acknowledge of a seed load

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: gnt=0, rnd=0, rnd_valid=0, seed_ready=0.
  - Internal: lfsr=SEED, round-robin pointer=0, FSM=IDLE.
  - Assertion mid-grant or mid-load aborts the operation; no partial step.
- LFSR step: next = {state[WIDTH-2:0], fb}. Default sequence from 0001 (period 15): 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001.
- FSM IDLE (all outputs low except rnd, which holds):
  - seed_valid=1 -> LOAD. Seeding has priority over req in the same cycle.
  - else any req bit set -> GRANT; the winner is the first set bit at or after the pointer, searching upward with wrap.
  - else stay in IDLE.
- FSM GRANT (1 cycle):
  - gnt[winner]=1, rnd=lfsr (pre-step value), rnd_valid=1.
  - At the end of the cycle: lfsr steps; pointer=(winner+1) mod NREQ; next state IDLE.
- FSM LOAD (1 cycle):
  - seed_ready=1.
  - lfsr = seed, or SEED if seed==0 (zero-seed guard).
  - Pointer unchanged. Next state IDLE.
- Latency:
  - req sampled high at edge k (FSM in IDLE) -> gnt visible in cycle k+1.
  - Maximum throughput is one grant every 2 cycles.
- Requester rule: deassert req at the edge that ends its gnt cycle. Because the FSM returns to IDLE and re-samples only at the following edge, no double grant occurs.
- A req held through the re-sample is treated as a new request.
- Lock-up guard: if lfsr==0 is observed in any state, lfsr=SEED at the next edge. This takes precedence over a step or load in that cycle.
- Fairness: with all NREQ requesters continuously active, each receives exactly one grant per NREQ grants.
- seed_valid held across multiple IDLE visits causes one load per visit. The requester deasserts it on seed_ready.

Decomposition:
- Shared package lfsr_pkg holds:
  - the FSM state enum (IDLE, GRANT, LOAD)
  - default TAPS/SEED constants for widths 4 and 8
  - a function computing the next LFSR state from state and taps
- One sub-module, lfsr_core (WIDTH, TAPS, SEED):
  - inputs: step, load, load_val; output: state
  - implements async active-low reset to SEED and the zero guard
- Arbitration and FSM live in lfsr_rr_sched.

Test Plan:
1. Reset release, req=01 held until gnt -> gnt=01 one cycle later, rnd=0001. Repeat for 3 more requests -> rnd=0010, 0100, 1001.
2. req=11 held continuously with the default config -> grants alternate 01,10,01,10 every 2 cycles; rnd=0001,0010,0100,1001; no requester gets two grants in a row.
3. seed_valid=1, seed=1010 together with req=01 -> seed_ready pulse first, gnt=01 two cycles later with rnd=1010; the next grant gives rnd=0101.
4. seed=0000 loaded -> seed_ready=1; the next grant gives rnd=0001 (SEED fallback).
5. reset driven low during a GRANT cycle -> gnt, rnd_valid and rnd go to 0 immediately. After release, the first grant gives rnd=0001 and the pointer restarts at requester 0.
6. Single requester draws 15 words -> sequence matches the 15-entry list above, then wraps to 0001. The all-zero word never appears.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR scheduler: FSM encoding, default polynomials, next-state function.
// Pure declarations; no timing or flow-control behaviour lives here.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOAD  = 2'd2
    } sched_state_t;

    // x^4+x^3+1 and x^8+x^6+x^5+x^4+1, both maximal length for a left-shifting Fibonacci LFSR
    localparam logic [3:0] TAPS4 = 4'b1100;
    localparam logic [3:0] SEED4 = 4'b0001;
    localparam logic [7:0] TAPS8 = 8'b1011_1000;
    localparam logic [7:0] SEED8 = 8'b0000_0001;

    // Widths up to 32 bits; the caller truncates the result to its own width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] st,
                                              input logic [31:0] taps,
                                              input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return ((st << 1) | {31'd0, ^(st & taps)}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_rr_sched_if.sv
// Requester-facing bundle of the LFSR scheduler: request/grant, random word and seed load handshake.
// master = requester side, slave = scheduler side.
interface lfsr_rr_sched_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rnd;
    logic             rnd_valid;
    logic             seed_valid;
    logic [WIDTH-1:0] seed;
    logic             seed_ready;

    modport master (
        output req, seed_valid, seed,
        input  gnt, rnd, rnd_valid, seed_ready
    );

    modport slave (
        input  req, seed_valid, seed,
        output gnt, rnd, rnd_valid, seed_ready
    );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with step/load controls, zero-seed substitution and all-zero lock-up recovery.
// State updates on the edge after step/load; no backpressure, the caller decides when it moves.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS4,
    parameter logic [WIDTH-1:0] SEED  = SEED4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] nxt;
    assign nxt = WIDTH'(lfsr_next(32'(state), 32'(TAPS), WIDTH));

    // Lock-up recovery outranks load and step so a zero state never survives an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else if (state == '0) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin arbiter handing out one LFSR word per grant; seed loads take priority over requests.
// gnt one cycle after req is sampled in IDLE, at most one grant per 2 cycles; requesters hold req until gnt.
module lfsr_rr_sched
    import lfsr_pkg::*;
#(
    parameter int               NREQ  = 2,
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS4,
    parameter logic [WIDTH-1:0] SEED  = SEED4
) (
    input  logic           clk,
    input  logic           reset,
    lfsr_rr_sched_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t     st;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    ptr_nxt;
    logic [NREQ-1:0]  win_oh;
    logic             found;
    logic [WIDTH-1:0] lfsr;
    int               idx;

    // First set request at or after the pointer, wrapping past NREQ-1.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[PW'(idx)]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh         = '0;
        win_oh[winner] = 1'b1;
    end

    assign ptr_nxt = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st             <= ST_IDLE;
            ptr            <= '0;
            bus.gnt        <= '0;
            bus.rnd        <= '0;
            bus.rnd_valid  <= 1'b0;
            bus.seed_ready <= 1'b0;
        end else begin
            bus.gnt        <= '0;
            bus.rnd_valid  <= 1'b0;
            bus.seed_ready <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (bus.seed_valid) begin
                        st             <= ST_LOAD;
                        bus.seed_ready <= 1'b1;
                    end else if (found) begin
                        // lfsr is stable across this edge, so it is the pre-step word of the GRANT cycle
                        st            <= ST_GRANT;
                        bus.gnt       <= win_oh;
                        bus.rnd       <= lfsr;
                        bus.rnd_valid <= 1'b1;
                        ptr           <= ptr_nxt;
                    end
                end
                ST_GRANT: st <= ST_IDLE;
                ST_LOAD:  st <= ST_IDLE;
                default:  st <= ST_IDLE;
            endcase
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .step     (st == ST_GRANT),
        .load     (st == ST_LOAD),
        .load_val (bus.seed),
        .state    (lfsr)
    );

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched with the default 2-requester, 4-bit x^4+x^3+1 configuration.
module tb_lfsr_rr_sched;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    lfsr_rr_sched_if #(.NREQ(2), .WIDTH(4)) bus ();

    lfsr_rr_sched #(
        .NREQ  (2),
        .WIDTH (4),
        .TAPS  (4'b1100),
        .SEED  (4'b0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        bus.req        = '0;
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Waits (bounded) for a grant and returns what was seen; a timeout returns gnt=0.
    task automatic wait_gnt(output logic [1:0] g, output logic [3:0] r,
                            output logic v, output int n);
        logic done;
        done = 1'b0;
        g = '0; r = '0; v = 1'b0; n = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            n++;
            if (bus.gnt !== 2'b00) begin
                g = bus.gnt; r = bus.rnd; v = bus.rnd_valid; done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
        n_cmp++; if (bus.rnd !== 4'b0000) begin n_bad++; $display("FAIL reset_rnd: got %b want 0000", bus.rnd); end
        n_cmp++; if (bus.rnd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rnd_valid: got %b want 0", bus.rnd_valid); end
        n_cmp++; if (bus.seed_ready !== 1'b0) begin n_bad++; $display("FAIL reset_seed_ready: got %b want 0", bus.seed_ready); end
    endtask

    task automatic test_single_req();
        logic [3:0] exp_r [0:3];
        logic [1:0] g; logic [3:0] r; logic v; int n;
        exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
        for (int k = 0; k < 4; k++) begin
            bus.req = 2'b01;
            wait_gnt(g, r, v, n);
            bus.req = 2'b00;
            n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL single_gnt[%0d]: got %b want 01", k, g); end
            n_cmp++; if (r !== exp_r[k]) begin n_bad++; $display("FAIL single_rnd[%0d]: got %b want %b", k, r, exp_r[k]); end
            n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d]: got %b want 1", k, v); end
            n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL single_latency[%0d]: got %0d cycles want 1", k, n); end
            tick();
            n_cmp++; if (bus.gnt !== 2'b00) begin n_bad++; $display("FAIL single_gnt_pulse[%0d]: got %b want 00", k, bus.gnt); end
            n_cmp++; if (bus.rnd !== exp_r[k]) begin n_bad++; $display("FAIL single_rnd_hold[%0d]: got %b want %b", k, bus.rnd, exp_r[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [0:7];
        logic [3:0] exp_r [0:7];
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_r = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1001, 4'b1001};
        apply_reset();
        bus.req = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++; if (bus.gnt !== exp_g[c]) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, bus.gnt, exp_g[c]); end
            n_cmp++; if (bus.rnd !== exp_r[c]) begin n_bad++; $display("FAIL b2b_rnd[%0d]: got %b want %b", c, bus.rnd, exp_r[c]); end
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_seed();
        logic [1:0] g; logic [3:0] r; logic v; int n;
        bus.seed_valid = 1'b1;
        bus.seed       = 4'b1010;
        bus.req        = 2'b01;
        tick();
        n_cmp++; if (bus.seed_ready !== 1'b1) begin n_bad++; $display("FAIL seed_ready: got %b want 1", bus.seed_ready); end
        n_cmp++; if (bus.gnt !== 2'b00) begin n_bad++; $display("FAIL seed_priority_gnt: got %b want 00", bus.gnt); end
        bus.seed_valid = 1'b0;
        tick();
        n_cmp++; if (bus.seed_ready !== 1'b0) begin n_bad++; $display("FAIL seed_ready_pulse: got %b want 0", bus.seed_ready); end
        n_cmp++; if (bus.gnt !== 2'b00) begin n_bad++; $display("FAIL seed_gap_gnt: got %b want 00", bus.gnt); end
        tick();
        n_cmp++; if (bus.gnt !== 2'b01) begin n_bad++; $display("FAIL seed_gnt: got %b want 01", bus.gnt); end
        n_cmp++; if (bus.rnd !== 4'b1010) begin n_bad++; $display("FAIL seed_rnd: got %b want 1010", bus.rnd); end
        bus.req = 2'b00;
        tick();
        bus.req = 2'b01;
        wait_gnt(g, r, v, n);
        bus.req = 2'b00;
        n_cmp++; if (r !== 4'b0101) begin n_bad++; $display("FAIL seed_next_rnd: got %b want 0101", r); end
        tick();
    endtask

    task automatic test_zero_seed();
        logic [1:0] g; logic [3:0] r; logic v; int n;
        bus.seed_valid = 1'b1;
        bus.seed       = 4'b0000;
        tick();
        n_cmp++; if (bus.seed_ready !== 1'b1) begin n_bad++; $display("FAIL zseed_ready: got %b want 1", bus.seed_ready); end
        bus.seed_valid = 1'b0;
        tick();
        bus.req = 2'b01;
        wait_gnt(g, r, v, n);
        bus.req = 2'b00;
        n_cmp++; if (r !== 4'b0001) begin n_bad++; $display("FAIL zseed_rnd: got %b want 0001", r); end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        logic [1:0] g; logic [3:0] r; logic v; int n;
        bus.req = 2'b01;
        wait_gnt(g, r, v, n);
        n_cmp++; if (r !== 4'b0010) begin n_bad++; $display("FAIL mid_pre_rnd: got %b want 0010", r); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.gnt !== 2'b00) begin n_bad++; $display("FAIL mid_gnt: got %b want 00", bus.gnt); end
        n_cmp++; if (bus.rnd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rnd_valid: got %b want 0", bus.rnd_valid); end
        n_cmp++; if (bus.rnd !== 4'b0000) begin n_bad++; $display("FAIL mid_rnd: got %b want 0000", bus.rnd); end
        bus.req = 2'b00;
        repeat (2) tick();
        reset   = 1'b1;
        bus.req = 2'b11;
        wait_gnt(g, r, v, n);
        bus.req = 2'b00;
        n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL mid_ptr_gnt: got %b want 01", g); end
        n_cmp++; if (r !== 4'b0001) begin n_bad++; $display("FAIL mid_after_rnd: got %b want 0001", r); end
        tick();
    endtask

    task automatic test_full_period();
        logic [3:0] exp_seq [0:15];
        logic [1:0] g; logic [3:0] r; logic v; int n;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                    4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            bus.req = 2'b01;
            wait_gnt(g, r, v, n);
            bus.req = 2'b00;
            n_cmp++; if (r !== exp_seq[k]) begin n_bad++; $display("FAIL period_rnd[%0d]: got %b want %b", k, r, exp_seq[k]); end
            n_cmp++; if (r === 4'b0000) begin n_bad++; $display("FAIL period_nonzero[%0d]: got %b want nonzero", k, r); end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.req        = '0;
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        test_reset();
        test_single_req();
        test_back_to_back();
        test_seed();
        test_zero_seed();
        test_reset_mid_grant();
        test_full_period();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
